counter_seq_ctrl: RTL
=====================

Name: counter_seq_ctrl

Overview:
- Sequencing controller for the board's 4-bit loadable counter datapath.
- Takes raw active-low pushbuttons and a one-shot switch, and issues single-cycle load and step commands to the counter.
- Runs an internal prescaler for free-running count mode.
- Watches the counter's current value so it can stop at a terminal count.
- Sits between the KEY/SW pins and the counter; the counter's value continues on to the BCD/7-segment display path.

Parameters:
- DEB_CYCLES, 500000: stable-sample count needed to accept a key level (10 ms at 50 MHz).
- TICK_DIV, 50000000: CLOCK_50 cycles per run-mode step (1 Hz).
- CNT_W, 4: counter value width.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz; only clock.
- rst_n  input  1  asynchronous, active-low reset.
- key_load_n  input  1  raw pushbutton, 0 = pressed, asynchronous.
- key_run_n  input  1  raw pushbutton, run/pause toggle, asynchronous.
- key_step_n  input  1  raw pushbutton, single step, asynchronous.
- sw_oneshot  input  1  1 = stop at term_val in run mode; static switch, used unsynchronised.
- term_val  input  CNT_W  terminal count value (switches).
- cnt_q  input  CNT_W  current counter value.
- load_pulse  output  1  one-cycle counter load strobe.
- step_pulse  output  1  one-cycle counter advance strobe.
- state  output  2  FSM state code.
- done  output  1  terminal count reached; held.
- tick  output  1  prescaler tick, one cycle, for LED/debug.

Behaviour:
- Reset (rst_n=0, async):
  - State IDLE; all outputs 0; prescaler 0.
  - Debounced levels forced to released (1); debounce counters 0.
  - Reset asserted mid-RUN or mid-LOAD aborts at once; no pulse is emitted on the release cycle.
- Key path, per key:
  - 2-FF synchroniser.
  - Debounce: the accepted level changes only after the synchronised level differs from it for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - Press event = one-cycle pulse on an accepted 1->0 transition. Release generates nothing.
  - Latency from a clean edge to the event: 2 + DEB_CYCLES cycles.
- Simultaneous events in one cycle: priority load > run > step. Lower-priority events are dropped, not queued.
- State codes: IDLE=0, LOAD=1, RUN=2, DONE=3.
- IDLE:
  - load event -> LOAD.
  - run event -> RUN; prescaler cleared to 0.
  - step event -> step_pulse=1 the next cycle; stay IDLE.
- LOAD:
  - load_pulse=1 for exactly this one cycle; done cleared.
  - Next state IDLE unconditionally. Events arriving in this cycle are dropped.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps; tick=1 on the cycle it equals TICK_DIV-1.
  - On a tick: if sw_oneshot=1 and cnt_q==term_val -> DONE, done=1, no step_pulse. Otherwise step_pulse=1 the next cycle.
  - run event -> IDLE (pause); prescaler held at 0.
  - load event -> LOAD.
  - step events ignored.
  - If an event and a tick coincide, the event wins and no step is issued.
- DONE:
  - done stays 1.
  - load event -> LOAD, which clears done.
  - run and step events ignored.
- Outputs are registered; step_pulse and load_pulse are never high in the same cycle.
- The controller never drives step_pulse on two consecutive cycles.
- The prescaler does not run outside RUN, so tick=0 outside RUN.

Decomposition:
- Package counter_seq_pkg:
  - state encoding constants (IDLE/LOAD/RUN/DONE, 2 bits);
  - default DEB_CYCLES and TICK_DIV.
- Counter widths derived with $clog2 of the parameters.
- One sub-module, key_debounce (synchroniser + debounce + press-event pulse), instantiated three times.
- FSM and prescaler live in the top module.

Test Plan (bench uses DEB_CYCLES=4, TICK_DIV=8):
- Reset then idle: rst_n low 3 cycles, keys released -> state=0, all outputs 0. Drop rst_n mid-RUN -> state=0 immediately, no pulse after release.
- Debounce: key_step_n bounces 0/1 every 2 cycles for 20 cycles, then held 0 -> exactly one step_pulse, 2+4+1 cycles after the stable low begins; release gives no pulse.
- Load: press key_load_n -> state 1 for one cycle with load_pulse=1, then state 0. A coincident run press is dropped, so state stays 0 afterwards.
- Run: press run -> tick every 8 cycles, with step_pulse one cycle after each tick. Model the counter incrementing cnt_q from 0 -> cnt_q goes 1,2,3 over 24 cycles. Press run again -> state 0, ticks stop.
- One-shot: sw_oneshot=1, term_val=5, cnt_q starting at 3 -> steps at cnt_q=3 and 4. At the tick with cnt_q=5: no step, state=3, done=1. Step and run presses are then ignored. A load press gives load_pulse and done=0.
- Collision: run event on the same cycle as tick=1 -> state 0, no step_pulse.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencing controller: state codes and default timing.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_DEB_CYCLES = 500000;
  localparam int unsigned DEF_TICK_DIV   = 50000000;
  localparam int unsigned DEF_CNT_W      = 4;

endpackage

// File: rtl/counter_seq_ctrl_key_debounce.sv
// One pushbutton: 2-FF synchroniser, stable-level debounce, and a one-cycle press event.
module key_debounce
  import counter_seq_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [DW-1:0] cnt_q;

  // Accepted level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      press  <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (cnt_q == DW'(DEB_CYCLES - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
          press   <= level_q;
        end else begin
          cnt_q <= cnt_q + DW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller: debounced keys drive load/step strobes, with a prescaled run mode
// that can stop at a terminal count.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             key_load_n,
  input  logic             key_run_n,
  input  logic             key_step_n,
  input  logic             sw_oneshot,
  input  logic [CNT_W-1:0] term_val,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             load_pulse,
  output logic             step_pulse,
  output logic [1:0]       state,
  output logic             done,
  output logic             tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic ev_load, ev_run, ev_step;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk(CLOCK_50), .rst_n(rst_n), .key_n(key_load_n), .press(ev_load));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(CLOCK_50), .rst_n(rst_n), .key_n(key_run_n), .press(ev_run));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk(CLOCK_50), .rst_n(rst_n), .key_n(key_step_n), .press(ev_step));

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          step_d, load_d, done_d, tick_d;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      step_pulse <= 1'b0;
      load_pulse <= 1'b0;
      done       <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      step_pulse <= step_d;
      load_pulse <= load_d;
      done       <= done_d;
      tick       <= tick_d;
    end
  end

  // Next state; events are prioritised load > run > step and an event beats a tick.
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    step_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_load)                   state_d = ST_LOAD;
        else if (ev_run)               state_d = ST_RUN;
        else if (ev_step && !step_pulse) step_d = 1'b1;
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_RUN: begin
        if (ev_load)     state_d = ST_LOAD;
        else if (ev_run) state_d = ST_IDLE;
        else if (tick) begin
          if (sw_oneshot && (cnt_q == term_val)) state_d = ST_DONE;
          else                                   step_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (ev_load) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    // Prescaler only advances while staying in RUN; entering RUN starts it from 0.
    if ((state_q == ST_RUN) && (state_d == ST_RUN))
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);

    tick_d = (state_d == ST_RUN) && (presc_d == PRESC_MAX);
    load_d = (state_d == ST_LOAD);

    done_d = done;
    if (state_d == ST_LOAD)      done_d = 1'b0;
    else if (state_d == ST_DONE) done_d = 1'b1;
  end

  assign state = state_q;

endmodule
